// File: rtl/bcd2bin_if.sv
// Handshake/data bundle for the BCD-to-binary converter.
interface bcd2bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  done;
  logic                  busy;
  logic                  err;

  modport master (output start, bcd_in, input bin_out, done, busy, err);
  modport slave  (input start, bcd_in, output bin_out, done, busy, err);
endinterface

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, shift/adjust per bit).
// Optional invalid-digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd2bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic      clk,
  input  logic      reset,
  bcd2bin_if.slave  bus
);
  localparam int BCD_W = 4*DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;

  state_t           state, state_nxt;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_q;
  logic             done_q;
  logic             err_q;

  // Per-nibble correction: a nibble >= 8 picked up a shifted-in 8 that should be 5.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = sr[BIN_W+4*g+3] ? (sr[BIN_W+4*g +: 4] - 4'd3)
                                               :  sr[BIN_W+4*g +: 4];
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   state_nxt = ADJUST;
      ADJUST:  state_nxt = (cnt == CNT_W'(BIN_W)) ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr     <= '0;
      cnt    <= '0;
      bin_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sr  <= {bus.bcd_in, {BIN_W{1'b0}}};
            cnt <= '0;
`ifdef BCD2BIN_CHECK_EN
            err_q <= bad;
`endif
          end
        end
        SHIFT: begin
          sr  <= sr >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        ADJUST: sr[SR_W-1:BIN_W] <= bcd_adj;
        DONE: begin
          bin_q  <= err_q ? '0 : sr[BIN_W-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: constant vectors, corner sequences, random vs decimal model.
module tb_bcd2bin;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus();
  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic bit bcd_ok(input logic [15:0] b);
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_dec(input logic [15:0] b);
    int v = 0;
    for (int i = DIGITS-1; i >= 0; i--) v = v*10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  // Starts one conversion from IDLE and waits (bounded) for done.
  task automatic run(input logic [15:0] bcd, input logic [13:0] exp_bin, input bit exp_err,
                     input bit chk_bin, input string nm);
    int n;
    bit got;
    int busy_low;
    busy_low = 0;
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_busy_e0"}, 32'(bus.busy), 1);
    chk({nm, "_done_e0"}, 32'(bus.done), 0);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) busy_low++;
    end
    chk({nm, "_latency"}, got ? n : -1, 2*BIN_W+1);
    chk({nm, "_busy_gap"}, busy_low, 0);
    chk({nm, "_busy_done"}, 32'(bus.busy), 0);
    if (chk_bin) chk({nm, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
    chk({nm, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  // mode 1: stray start at edge 10; mode 2: reset at edge 12; mode 3: bcd_in scrambled each cycle.
  task automatic seq(input logic [15:0] bcd, input int mode, input logic [13:0] exp_bin,
                     input int exp_ndone, input string nm);
    int ndone;
    int first;
    ndone = 0;
    first = -1;
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      if (mode == 1 && n == 10) begin bus.start = 1'b1; bus.bcd_in = 16'h0007; end
      if (mode == 2 && n == 12) reset = 1'b1;
      if (mode == 3) bus.bcd_in = 16'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
      reset = 1'b0;
      if (mode == 2 && n == 12) begin
        chk({nm, "_rst_bin"}, 32'(bus.bin_out), 0);
        chk({nm, "_rst_done"}, 32'(bus.done), 0);
        chk({nm, "_rst_busy"}, 32'(bus.busy), 0);
      end
      if (bus.done) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    chk({nm, "_ndone"}, ndone, exp_ndone);
    if (exp_ndone > 0) chk({nm, "_first"}, first, 2*BIN_W+1);
    chk({nm, "_bin_hold"}, 32'(bus.bin_out), 32'(exp_bin));
    chk({nm, "_busy_end"}, 32'(bus.busy), 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] r;
    bit rbad;
    logic [13:0] rbin;

    tbl[0] = '{16'h1234, 14'h04D2};
    tbl[1] = '{16'h9999, 14'h270F};
    tbl[2] = '{16'h0000, 14'd0};
    tbl[3] = '{16'h0042, 14'd42};
    tbl[4] = '{16'h0321, 14'd321};
    tbl[5] = '{16'h5000, 14'd5000};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", 32'(bus.bin_out), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);

    // reset and start together: start must not be taken
    bus.start = 1'b1;
    bus.bcd_in = 16'h1111;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy0", 32'(bus.busy), 0);
    @(posedge clk); #1;
    chk("rst_start_busy1", 32'(bus.busy), 0);
    chk("rst_start_done", 32'(bus.done), 0);

    // back-to-back: each run issues start in the done cycle of the previous one
    for (int i = 0; i < 6; i++)
      run(tbl[i].bcd, tbl[i].bin, 1'b0, 1'b1, $sformatf("tbl%0d", i));

    seq(16'h0500, 1, 14'd500, 1, "ignore_start");
    seq(16'h8765, 2, 14'd0, 0, "mid_reset");
    run(16'h0001, 14'd1, 1'b0, 1'b1, "after_reset");

`ifdef BCD2BIN_CHECK_EN
    run(16'h12A4, 14'd0, 1'b1, 1'b1, "invalid");
`else
    run(16'h12A4, 14'd0, 1'b0, 1'b0, "invalid");
`endif
    run(16'h0010, 14'd10, 1'b0, 1'b1, "after_invalid");

    seq(16'h0321, 3, 14'd321, 1, "scramble");

    for (int k = 0; k < 24; k++) begin
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
        r[4*d +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD2BIN_CHECK_EN
        if ($urandom_range(0, 7) == 0) r[4*d +: 4] = 4'($urandom_range(10, 15));
`endif
      end
      rbad = !bcd_ok(r);
      rbin = rbad ? 14'd0 : 14'(bcd_dec(r));
      run(r, rbin, rbad, 1'b1, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
